keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_scan_timer.sv | 45 ++++
 rtl/keypad_scanner.sv | 237 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and helpers for the 4x4 keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } kp_state_e;

    typedef enum logic [1:0] {
        FRAME_NONE,
        FRAME_SINGLE,
        FRAME_MULTI
    } frame_res_e;

    // Number of low rows in one column sample, saturated at 2 (only 0/1/many matter)
    function automatic logic [1:0] low_count_sat(input logic [NUM_ROWS-1:0] low);
        logic [2:0] n;
        n = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
        return (n >= 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest low row; only meaningful when exactly one row is low
    function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] low);
        if (low[0])      return 2'd0;
        else if (low[1]) return 2'd1;
        else if (low[2]) return 2'd2;
        else             return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// rtl/keypad_scan_timer.sv - column dwell divider, scan tick and active-low column rotator
module keypad_scan_timer
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic                Clk,
    input  logic                Rst_n,
    output logic                tick,
    output logic [1:0]          col_idx,
    output logic [NUM_COLS-1:0] col_sel
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_sel_q, col_sel_d;

    // Terminal count gives the tick; the column advances on the same tick it is sampled
    always_comb begin
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + 1'b1;
        col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
        col_sel_d = tick ? {col_sel_q[NUM_COLS-2:0], col_sel_q[NUM_COLS-1]} : col_sel_q;
    end

    // Divider and column state registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_sel_q <= 4'b1110;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            col_sel_q <= col_sel_d;
        end
    end

    assign col_idx = col_idx_q;
    assign col_sel = col_sel_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce and valid/ack report path (option: KEYPAD_AUTOREPEAT_EN)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 125
) (
    input  logic                Clk,
    input  logic                Rst_n,
    output logic [NUM_COLS-1:0] ColSel,
    input  logic [NUM_ROWS-1:0] Row,
    output logic [CODE_W-1:0]   KeyCode,
    output logic                KeyValid,
    input  logic                KeyAck,
    output logic                KeyHeld,
    output logic                Overrun
);

    // Debounce counter only ever holds 0..DEBOUNCE_SCANS-1; reaching the target transitions
    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic                tick;
    logic [1:0]          col_idx;
    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic [1:0]          acc_cnt_q, acc_cnt_d;
    logic [CODE_W-1:0]   acc_code_q, acc_code_d;
    logic [1:0]          col_cnt, frame_cnt;
    logic [2:0]          sum_w;
    logic [CODE_W-1:0]   frame_code;
    logic                frame_eval;
    frame_res_e          frame_res;

    kp_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   cand_q, cand_d;
    logic                report;
    logic [CODE_W-1:0]   report_code;
    logic                valid_q, valid_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                held_q, held_d;
    logic                ovr_q, ovr_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
`else
    logic                unused_repeat_scans;
    assign unused_repeat_scans = ^REPEAT_SCANS;
`endif

    keypad_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .tick    (tick),
        .col_idx (col_idx),
        .col_sel (ColSel)
    );

    // Fold each column sample into the running frame result; classify on the column-3 tick
    always_comb begin
        col_cnt    = low_count_sat(~row_sync_q);
        sum_w      = {1'b0, acc_cnt_q} + {1'b0, col_cnt};
        frame_cnt  = (sum_w >= 3'd2) ? 2'd2 : sum_w[1:0];
        frame_code = (acc_cnt_q == 2'd0 && col_cnt == 2'd1) ? {low_index(~row_sync_q), col_idx}
                                                             : acc_code_q;
        frame_eval = tick && (col_idx == 2'd3);
        case (frame_cnt)
            2'd0:    frame_res = FRAME_NONE;
            2'd1:    frame_res = FRAME_SINGLE;
            default: frame_res = FRAME_MULTI;
        endcase
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (frame_eval) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = '0;
        end else if (tick) begin
            acc_cnt_d  = frame_cnt;
            acc_code_d = frame_code;
        end
    end

    // Row synchronizer and frame accumulator
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
        end else begin
            row_meta_q <= Row;
            row_sync_q <= row_meta_q;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Debounce FSM advances once per frame; report path follows the valid/ack rules
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        report      = 1'b0;
        report_code = cand_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        if (frame_eval) begin
            case (state_q)
                IDLE: begin
                    if (frame_res == FRAME_SINGLE) begin
                        cand_d = frame_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d     = PRESSED;
                            cnt_d       = '0;
                            report      = 1'b1;
                            report_code = frame_code;
                        end else begin
                            state_d = DEB_PRESS;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEB_PRESS: begin
                    if (frame_res == FRAME_SINGLE && frame_code == cand_q) begin
                        if (cnt_q >= DEB_LAST) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            report  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (frame_res == FRAME_NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = DEB_RELEASE;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_cnt_q >= REP_LAST) begin
                            report    = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                DEB_RELEASE: begin
                    if (frame_res == FRAME_NONE) begin
                        if (cnt_q >= DEB_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
`ifdef KEYPAD_AUTOREPEAT_EN
            if (state_q != PRESSED || state_d != PRESSED) begin
                rep_cnt_d = '0;
            end
`endif
        end

        valid_d = valid_q;
        code_d  = code_q;
        ovr_d   = ovr_q;
        if (KeyAck) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (report) begin
            valid_d = 1'b1;
            code_d  = report_code;
            if (valid_q && !KeyAck) begin
                ovr_d = 1'b1;
            end
        end
        held_d = (state_d == PRESSED) || (state_d == DEB_RELEASE);
    end

    // FSM state, debounce counters and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            held_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            held_q    <= held_d;
            ovr_q     <= ovr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    assign KeyCode  = code_q;
    assign KeyValid = valid_q;
    assign KeyHeld  = held_q;
    assign Overrun  = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner (option: KEYPAD_AUTOREPEAT_EN)
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        Clk    = 1'b0;
    logic        Rst_n  = 1'b1;
    logic        KeyAck = 1'b0;
    logic [3:0]  Row;
    logic [3:0]  ColSel;
    logic [3:0]  KeyCode;
    logic        KeyValid, KeyHeld, Overrun;
    logic [15:0] keys = 16'h0;
    int          checks = 0;
    int          fails  = 0;
    int          cyc;

    always #5 Clk = ~Clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low
    always_comb begin
        Row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!ColSel[c] && keys[r*4+c]) Row[r] = 1'b0;
    end

    // Cycles since reset release; frames end on multiples of 16 (SCAN_DIV=4)
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .ColSel   (ColSel),
        .Row      (Row),
        .KeyCode  (KeyCode),
        .KeyValid (KeyValid),
        .KeyAck   (KeyAck),
        .KeyHeld  (KeyHeld),
        .Overrun  (Overrun)
    );

    task automatic wait_frame_end();
        do begin
            @(posedge Clk);
            #1;
        end while (cyc % 16 != 0);
    endtask

    task automatic frames(input int n);
        repeat (n) wait_frame_end();
    endtask

    task automatic ack_pulse();
        KeyAck = 1'b1;
        @(posedge Clk);
        #1;
        KeyAck = 1'b0;
    endtask

    task automatic test_reset();
        #1 Rst_n = 1'b0;
        #11;
        checks++; if (ColSel !== 4'b1110) begin fails++; $display("FAIL rst_colsel: got %b want 1110", ColSel); end
        checks++; if (KeyCode !== 4'h0) begin fails++; $display("FAIL rst_code: got %h want 0", KeyCode); end
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", KeyValid); end
        checks++; if (KeyHeld !== 1'b0) begin fails++; $display("FAIL rst_held: got %b want 0", KeyHeld); end
        checks++; if (Overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %b want 0", Overrun); end
        keys = 16'h1 << 9;
        @(negedge Clk) Rst_n = 1'b1;
        wait_frame_end();
        checks++; if (dut.state_q !== DEB_PRESS) begin fails++; $display("FAIL rst_deb_press: got %0d want %0d", dut.state_q, DEB_PRESS); end
        repeat (5) @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        checks++; if (ColSel !== 4'b1110) begin fails++; $display("FAIL rst_mid_colsel: got %b want 1110", ColSel); end
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", KeyValid); end
        checks++; if (KeyHeld !== 1'b0) begin fails++; $display("FAIL rst_mid_held: got %b want 0", KeyHeld); end
        checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state_q, IDLE); end
        keys = 16'h0;
        @(negedge Clk) Rst_n = 1'b1;
        frames(3);
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL rst_no_report: got %b want 0", KeyValid); end
    endtask

    task automatic test_press();
        keys = 16'h1 << 9;
        wait_frame_end();
        repeat (15) @(posedge Clk);
        #1;
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL press_early: got %b want 0", KeyValid); end
        @(posedge Clk);
        #1;
        checks++; if (KeyValid !== 1'b1) begin fails++; $display("FAIL press_valid: got %b want 1", KeyValid); end
        checks++; if (KeyCode !== 4'h9) begin fails++; $display("FAIL press_code: got %h want 9", KeyCode); end
        checks++; if (KeyHeld !== 1'b1) begin fails++; $display("FAIL press_held: got %b want 1", KeyHeld); end
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (KeyValid !== 1'b1) begin fails++; $display("FAIL press_hold_valid: got %b want 1", KeyValid); end
        ack_pulse();
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL press_ack: got %b want 0", KeyValid); end
        checks++; if (KeyCode !== 4'h9) begin fails++; $display("FAIL press_code_kept: got %h want 9", KeyCode); end
        wait_frame_end();
        keys = 16'h0;
        wait_frame_end();
        checks++; if (KeyHeld !== 1'b1) begin fails++; $display("FAIL release_deb_held: got %b want 1", KeyHeld); end
        wait_frame_end();
        checks++; if (KeyHeld !== 1'b0) begin fails++; $display("FAIL release_held: got %b want 0", KeyHeld); end
        checks++; if (Overrun !== 1'b0) begin fails++; $display("FAIL press_overrun: got %b want 0", Overrun); end
    endtask

    task automatic test_bounce();
        keys = 16'h1 << 3;
        wait_frame_end();
        checks++; if (dut.state_q !== DEB_PRESS) begin fails++; $display("FAIL bounce_deb: got %0d want %0d", dut.state_q, DEB_PRESS); end
        keys = 16'h0;
        wait_frame_end();
        checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL bounce_idle: got %0d want %0d", dut.state_q, IDLE); end
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL bounce_valid: got %b want 0", KeyValid); end
        keys = 16'h1 << 3;
        wait_frame_end();
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL bounce_restart: got %b want 0", KeyValid); end
        wait_frame_end();
        checks++; if (KeyValid !== 1'b1 || KeyCode !== 4'h3) begin fails++; $display("FAIL bounce_report: got %b/%h want 1/3", KeyValid, KeyCode); end
        keys = 16'h0;
        ack_pulse();
        frames(2);
    endtask

    task automatic test_chord();
        keys = (16'h1 << 0) | (16'h1 << 7);
        for (int f = 0; f < 4; f++) begin
            wait_frame_end();
            checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL chord_state f%0d: got %0d want %0d", f, dut.state_q, IDLE); end
            checks++; if (KeyValid !== 1'b0 || KeyHeld !== 1'b0) begin fails++; $display("FAIL chord_report f%0d: got %b/%b want 0/0", f, KeyValid, KeyHeld); end
        end
        keys = 16'h0;
        wait_frame_end();
    endtask

    task automatic test_overrun();
        keys = 16'h1 << 5;
        frames(2);
        checks++; if (KeyValid !== 1'b1 || KeyCode !== 4'h5 || Overrun !== 1'b0) begin fails++; $display("FAIL ovr_first: got %b/%h/%b want 1/5/0", KeyValid, KeyCode, Overrun); end
        keys = 16'h0;
        frames(2);
        keys = 16'h1 << 7;
        frames(2);
        checks++; if (KeyCode !== 4'h7) begin fails++; $display("FAIL ovr_code: got %h want 7", KeyCode); end
        checks++; if (KeyValid !== 1'b1 || Overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b/%b want 1/1", KeyValid, Overrun); end
        keys = 16'h0;
        ack_pulse();
        checks++; if (KeyValid !== 1'b0 || Overrun !== 1'b0) begin fails++; $display("FAIL ovr_ack: got %b/%b want 0/0", KeyValid, Overrun); end
        ack_pulse();
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL ovr_idle_ack: got %b want 0", KeyValid); end
        frames(2);
    endtask

    task automatic test_ack_collision();
        keys = 16'h1 << 10;
        frames(2);
        checks++; if (KeyValid !== 1'b1 || KeyCode !== 4'hA) begin fails++; $display("FAIL coll_first: got %b/%h want 1/a", KeyValid, KeyCode); end
        keys = 16'h0;
        frames(2);
        keys = 16'h1 << 4;
        wait_frame_end();
        repeat (15) @(posedge Clk);
        #1;
        ack_pulse();
        checks++; if (KeyValid !== 1'b1 || KeyCode !== 4'h4) begin fails++; $display("FAIL coll_report: got %b/%h want 1/4", KeyValid, KeyCode); end
        checks++; if (Overrun !== 1'b0) begin fails++; $display("FAIL coll_overrun: got %b want 0", Overrun); end
        keys = 16'h0;
        ack_pulse();
        checks++; if (KeyValid !== 1'b0) begin fails++; $display("FAIL coll_ack: got %b want 0", KeyValid); end
        frames(2);
    endtask

    task automatic test_repeat();
        int nrep;
        int rep_at [8];
`ifdef KEYPAD_AUTOREPEAT_EN
        int exp_n = 4;
        int exp_at [4] = '{32, 80, 128, 176};
`else
        int exp_n = 1;
        int exp_at [4] = '{32, 0, 0, 0};
`endif
        nrep = 0;
        keys = 16'h1 << 12;
        for (int c = 1; c <= 12 * 16; c++) begin
            @(posedge Clk);
            #1;
            if (KeyValid) begin
                if (nrep < 8) rep_at[nrep] = c;
                nrep++;
                KeyAck = 1'b1;
            end else begin
                KeyAck = 1'b0;
            end
        end
        KeyAck = 1'b0;
        checks++; if (nrep != exp_n) begin fails++; $display("FAIL repeat_count: got %0d want %0d", nrep, exp_n); end
        for (int i = 0; i < exp_n && i < nrep; i++) begin
            checks++; if (rep_at[i] != exp_at[i]) begin fails++; $display("FAIL repeat_time %0d: got %0d want %0d", i, rep_at[i], exp_at[i]); end
        end
        checks++; if (KeyCode !== 4'hC || KeyHeld !== 1'b1) begin fails++; $display("FAIL repeat_code: got %h/%b want c/1", KeyCode, KeyHeld); end
        checks++; if (Overrun !== 1'b0) begin fails++; $display("FAIL repeat_overrun: got %b want 0", Overrun); end
        keys = 16'h0;
        frames(2);
        checks++; if (KeyHeld !== 1'b0 || KeyValid !== 1'b0) begin fails++; $display("FAIL repeat_release: got %b/%b want 0/0", KeyHeld, KeyValid); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_chord();
        test_overrun();
        test_ack_collision();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
